// File: rtl/fpu_mds_sched_if.sv
// rtl/fpu_mds_sched_if.sv - issue/writeback signal bundle for the div/sqrt scheduler
interface fpu_mds_sched_if;
    logic        start;
    logic        op;
    logic        hold;
    logic [4:0]  id_fs;
    logic [4:0]  id_ft;
    logic [4:0]  id_fd;
    logic        rd_fs;
    logic        rd_ft;
    logic        id_wf;
    logic        e3w;
    logic        u_start;
    logic        u_op;
    logic        busy;
    logic        stall_mds;
    logic        wb_en;
    logic [4:0]  wb_rn;
    logic [15:0] stall_cnt;

    // Pipeline side: drives the ID-stage view, observes scheduler outputs
    modport master (
        output start, op, hold, id_fs, id_ft, id_fd, rd_fs, rd_ft, id_wf, e3w,
        input  u_start, u_op, busy, stall_mds, wb_en, wb_rn, stall_cnt
    );

    // Scheduler side
    modport slave (
        input  start, op, hold, id_fs, id_ft, id_fd, rd_fs, rd_ft, id_wf, e3w,
        output u_start, u_op, busy, stall_mds, wb_en, wb_rn, stall_cnt
    );
endinterface

// File: rtl/fpu_mds_sched.sv
// rtl/fpu_mds_sched.sv - issue/hazard/writeback scheduler for iterative fdiv/fsqrt
module fpu_mds_sched #(
    parameter int DIV_LAT  = 8,
    parameter int SQRT_LAT = 6
) (
    input  logic           clock,
    input  logic           reset,
    fpu_mds_sched_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        WB   = 2'd2
    } state_t;

    localparam logic [4:0] DIV_CNT  = 5'(DIV_LAT - 1);
    localparam logic [4:0] SQRT_CNT = 5'(SQRT_LAT - 1);

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [4:0]  pdest_q, pdest_d;
    logic        u_op_q, u_op_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic        accept;
    logic        busy;
    logic        wb_en;
    logic        hazard;
    logic        stall_mds;

    // Next-state, launch, writeback and hazard logic; reset masks all pulses
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pdest_d     = pdest_q;
        u_op_d      = u_op_q;
        stall_cnt_d = stall_cnt_q;

        busy   = (state_q != IDLE);
        accept = bus.start & ~bus.hold & (state_q == IDLE) & ~reset;
        wb_en  = (state_q == WB) & ~bus.e3w & ~reset;
        hazard = bus.start
               | (bus.rd_fs & (bus.id_fs == pdest_q))
               | (bus.rd_ft & (bus.id_ft == pdest_q))
               | (bus.id_wf & (bus.id_fd == pdest_q));
        // Stall stays up through the writeback cycle: no same-cycle bypass exists
        stall_mds = busy & hazard & ~reset;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUSY;
                    pdest_d = bus.id_fd;
                    u_op_d  = bus.op;
                    cnt_d   = bus.op ? SQRT_CNT : DIV_CNT;
                end
            end
            BUSY: begin
                if (cnt_q == 5'd0) begin
                    state_d = WB;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            WB: begin
                // Pipelined FPU owns the write port when e3w is set; wait it out
                if (wb_en) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (stall_mds && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // State register with synchronous reset that abandons any pending op
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 5'd0;
            pdest_q     <= 5'd0;
            u_op_q      <= 1'b0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pdest_q     <= pdest_d;
            u_op_q      <= u_op_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.u_start   = accept;
    assign bus.u_op      = u_op_q;
    assign bus.busy      = busy;
    assign bus.stall_mds = stall_mds;
    assign bus.wb_en     = wb_en;
    assign bus.wb_rn     = pdest_q;
    assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_fpu_mds_sched.sv
// tb/tb_fpu_mds_sched.sv - directed self-checking bench for fpu_mds_sched
module tb_fpu_mds_sched;
    logic clock;
    logic reset;
    int   checks;
    int   errors;

    fpu_mds_sched_if bus ();

    fpu_mds_sched #(.DIV_LAT(8), .SQRT_LAT(6)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the start of the next cycle (just after the rising edge)
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Move to mid-cycle, after inputs have settled, for sampling
    task automatic mid();
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        bus.start = 0; bus.op = 0; bus.hold = 0;
        bus.id_fs = 0; bus.id_ft = 0; bus.id_fd = 0;
        bus.rd_fs = 0; bus.rd_ft = 0; bus.id_wf = 0; bus.e3w = 0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle_inputs();
        reset = 1;

        // Reset: outputs forced low even with start asserted
        tick();
        bus.start = 1; bus.id_fd = 5'd12;
        mid();
        chk("rst_u_start", 16'(bus.u_start), 16'd0);
        chk("rst_wb_en", 16'(bus.wb_en), 16'd0);
        chk("rst_stall", 16'(bus.stall_mds), 16'd0);
        tick();
        idle_inputs();
        reset = 0;
        mid();
        chk("rst_busy", 16'(bus.busy), 16'd0);
        chk("rst_wb_rn", 16'(bus.wb_rn), 16'd0);
        chk("rst_u_op", 16'(bus.u_op), 16'd0);
        chk("rst_stall_cnt", bus.stall_cnt, 16'd0);

        // Basic divide to f5
        tick();
        bus.start = 1; bus.op = 0; bus.id_fd = 5'd5;
        mid();
        chk("div_u_start_c0", 16'(bus.u_start), 16'd1);
        chk("div_stall_c0", 16'(bus.stall_mds), 16'd0);
        for (int c = 1; c <= 9; c++) begin
            tick();
            bus.start = 0; bus.id_fd = 0;
            mid();
            chk($sformatf("div_busy_c%0d", c), 16'(bus.busy), 16'd1);
            chk($sformatf("div_wb_en_c%0d", c), 16'(bus.wb_en), (c == 9) ? 16'd1 : 16'd0);
            chk($sformatf("div_stall_c%0d", c), 16'(bus.stall_mds), 16'd0);
        end
        chk("div_wb_rn", 16'(bus.wb_rn), 16'd5);
        tick();
        mid();
        chk("div_idle_c10", 16'(bus.busy), 16'd0);
        chk("div_stall_cnt", bus.stall_cnt, 16'd0);

        // Sqrt to f7 with write-port conflict in cycles 7-9
        tick();
        bus.start = 1; bus.op = 1; bus.id_fd = 5'd7;
        mid();
        chk("sq_u_start_c0", 16'(bus.u_start), 16'd1);
        for (int c = 1; c <= 10; c++) begin
            tick();
            bus.start = 0; bus.op = 0; bus.id_fd = 0;
            bus.e3w = (c >= 7 && c <= 9);
            mid();
            chk($sformatf("sq_busy_c%0d", c), 16'(bus.busy), 16'd1);
            chk($sformatf("sq_wb_en_c%0d", c), 16'(bus.wb_en), (c == 10) ? 16'd1 : 16'd0);
        end
        chk("sq_u_op", 16'(bus.u_op), 16'd1);
        chk("sq_wb_rn", 16'(bus.wb_rn), 16'd7);
        tick();
        bus.e3w = 0;
        mid();
        chk("sq_idle_c11", 16'(bus.busy), 16'd0);

        // RAW hazard: ID reads ft = f3 while a divide to f3 is pending
        tick();
        bus.start = 1; bus.op = 0; bus.id_fd = 5'd3;
        mid();
        chk("raw_stall_c0", 16'(bus.stall_mds), 16'd0);
        for (int c = 1; c <= 9; c++) begin
            tick();
            bus.start = 0; bus.id_fd = 0;
            bus.rd_ft = 1; bus.id_ft = 5'd3;
            mid();
            chk($sformatf("raw_stall_c%0d", c), 16'(bus.stall_mds), 16'd1);
        end
        chk("raw_wb_en_c9", 16'(bus.wb_en), 16'd1);
        tick();
        mid();
        chk("raw_stall_c10", 16'(bus.stall_mds), 16'd0);
        chk("raw_stall_cnt", bus.stall_cnt, 16'd9);
        idle_inputs();

        // Back-to-back: divide to f2, then a sqrt to f9 held from cycle 1
        tick();
        bus.start = 1; bus.op = 0; bus.id_fd = 5'd2;
        mid();
        chk("b2b_u_start_c0", 16'(bus.u_start), 16'd1);
        for (int c = 1; c <= 9; c++) begin
            tick();
            bus.start = 1; bus.op = 1; bus.id_fd = 5'd9;
            mid();
            chk($sformatf("b2b_stall_c%0d", c), 16'(bus.stall_mds), 16'd1);
            chk($sformatf("b2b_u_start_c%0d", c), 16'(bus.u_start), 16'd0);
        end
        chk("b2b_first_wb_rn", 16'(bus.wb_rn), 16'd2);
        tick();
        mid();
        chk("b2b_u_start_c10", 16'(bus.u_start), 16'd1);
        chk("b2b_stall_c10", 16'(bus.stall_mds), 16'd0);
        tick();
        idle_inputs();
        mid();
        chk("b2b_wb_rn_c11", 16'(bus.wb_rn), 16'd9);
        chk("b2b_u_op_c11", 16'(bus.u_op), 16'd1);
        chk("b2b_stall_cnt", bus.stall_cnt, 16'd18);
        for (int c = 12; c <= 17; c++) begin
            tick();
            mid();
            chk($sformatf("b2b_wb_en_c%0d", c), 16'(bus.wb_en), (c == 17) ? 16'd1 : 16'd0);
        end
        tick();
        mid();
        chk("b2b_idle_c18", 16'(bus.busy), 16'd0);

        // hold gating: start with hold for 3 cycles
        for (int c = 0; c < 3; c++) begin
            tick();
            bus.start = 1; bus.op = 0; bus.id_fd = 5'd4; bus.hold = 1;
            mid();
            chk($sformatf("hold_u_start_h%0d", c), 16'(bus.u_start), 16'd0);
            chk($sformatf("hold_stall_h%0d", c), 16'(bus.stall_mds), 16'd0);
        end
        tick();
        bus.hold = 0;
        mid();
        chk("hold_u_start_rel", 16'(bus.u_start), 16'd1);
        chk("hold_stall_rel", 16'(bus.stall_mds), 16'd0);
        tick();
        idle_inputs();
        mid();
        chk("hold_wb_rn", 16'(bus.wb_rn), 16'd4);
        for (int c = 2; c <= 10; c++) begin
            tick();
        end
        mid();
        chk("hold_done_idle", 16'(bus.busy), 16'd0);

        // Reset in cycle 4 of a divide to f6
        tick();
        bus.start = 1; bus.op = 0; bus.id_fd = 5'd6;
        mid();
        chk("mrst_u_start_c0", 16'(bus.u_start), 16'd1);
        for (int c = 1; c <= 4; c++) begin
            tick();
            bus.start = 0; bus.id_fd = 0;
            bus.rd_fs = 1; bus.id_fs = 5'd6;
            reset = (c == 4);
            mid();
            if (c < 4) chk($sformatf("mrst_stall_c%0d", c), 16'(bus.stall_mds), 16'd1);
        end
        chk("mrst_stall_in_rst", 16'(bus.stall_mds), 16'd0);
        chk("mrst_wb_en_in_rst", 16'(bus.wb_en), 16'd0);
        tick();
        reset = 0;
        mid();
        chk("mrst_busy_c5", 16'(bus.busy), 16'd0);
        chk("mrst_stall_cnt", bus.stall_cnt, 16'd0);
        chk("mrst_wb_rn", 16'(bus.wb_rn), 16'd0);
        for (int c = 6; c <= 14; c++) begin
            tick();
            mid();
            chk($sformatf("mrst_no_wb_c%0d", c), 16'(bus.wb_en), 16'd0);
        end
        chk("mrst_final_stall_cnt", bus.stall_cnt, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
